// File: rtl/oled_frame_sched_if.sv
// oled_frame_sched_if: scan-pulse, position and
// update-slot handshake bundle for oled_frame_sched.
interface oled_frame_sched_if #(
  parameter int NREQ = 4
);
  logic            frame_begin;
  logic            sample_pixel;
  logic [6:0]      pixel_x;
  logic [5:0]      pixel_y;
  logic            scan_active;
  logic [NREQ-1:0] upd_req;
  logic [NREQ-1:0] upd_gnt;
  logic [NREQ-1:0] upd_done;
  logic            overrun;

  modport master (
    output frame_begin, sample_pixel,
    output upd_req, upd_done,
    input  pixel_x, pixel_y, scan_active,
    input  upd_gnt, overrun
  );

  modport slave (
    input  frame_begin, sample_pixel,
    input  upd_req, upd_done,
    output pixel_x, pixel_y, scan_active,
    output upd_gnt, overrun
  );
endinterface

// File: rtl/oled_frame_sched.sv
// oled_frame_sched: OLED scan position tracker with a
// blanking-window round-robin update-slot arbiter.
module oled_frame_sched #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64,
  parameter int NREQ   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  oled_frame_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE, SCAN, BLANK, GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      x_q, x_d;
  logic [5:0]      y_q, y_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_idx;
  logic [IW:0]     cand;
  logic            ovr_q, ovr_d;
  logic            sel_found;
  logic            last_x, last_y;

  assign last_x = (x_q == 7'(WIDTH - 1));
  assign last_y = (y_q == 6'(HEIGHT - 1));

  // Round-robin: first requester after the last grantee.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!sel_found && bus.upd_req[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    ovr_d   = ovr_q;
    if (bus.frame_begin) begin
      state_d = SCAN;
      x_d     = '0;
      y_d     = '0;
      gnt_d   = '0;
      if (state_q == GRANT) begin
        ptr_d = gidx_q;
        if (!bus.upd_done[gidx_q])
          ovr_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        SCAN: begin
          if (bus.sample_pixel) begin
            if (!last_x) begin
              x_d = x_q + 7'd1;
            end else if (!last_y) begin
              x_d = '0;
              y_d = y_q + 6'd1;
            end else begin
              state_d = BLANK;
            end
          end
        end
        BLANK: begin
          if (sel_found) begin
            state_d        = GRANT;
            gnt_d          = '0;
            gnt_d[sel_idx] = 1'b1;
            gidx_d         = sel_idx;
          end
        end
        GRANT: begin
          if (bus.upd_done[gidx_q]) begin
            state_d = BLANK;
            gnt_d   = '0;
            ptr_d   = gidx_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= IW'(NREQ - 1);
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.scan_active = (state_q == SCAN);
  assign bus.upd_gnt     = gnt_q;
  assign bus.overrun     = ovr_q;
endmodule
